// File: rtl/afifo_word_assembler.sv
// rtl/afifo_word_assembler.sv - read-domain FIFO consumer packing beats into words
module afifo_word_assembler #(
    parameter int DATA_WIDTH = 8,
    parameter int BEATS      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                          rclk,
    input  logic                          r_nrst,
    input  logic [DATA_WIDTH-1:0]         fifo_rdata,
    input  logic                          fifo_empty,
    output logic                          fifo_rinc,
    input  logic                          flush,
    output logic [DATA_WIDTH*BEATS-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_partial,
    output logic [$clog2(BEATS+1)-1:0]    out_count
);

    localparam int CW = $clog2(BEATS+1);
    localparam int IW = $clog2(TIMEOUT+1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS-1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(BEATS);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT-1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idle;

    // Pop is combinational so a beat is consumed on the same edge it is stored.
    assign fifo_rinc = (state == FILL) && !fifo_empty && !flush;

    always_ff @(posedge rclk or negedge r_nrst) begin
        if (!r_nrst) begin
            state       <= FILL;
            cnt         <= '0;
            idle        <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_partial <= 1'b0;
            out_count   <= '0;
        end else if (flush) begin
            state       <= FILL;
            cnt         <= '0;
            idle        <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_partial <= 1'b0;
            out_count   <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (fifo_rinc) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (cnt == CW'(i)) begin
                                out_data[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_rdata;
                            end
                        end
                        idle <= '0;
                        if (cnt == LAST_BEAT) begin
                            state       <= HOLD;
                            out_valid   <= 1'b1;
                            out_count   <= FULL_CNT;
                            out_partial <= 1'b0;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (cnt != '0) begin
                        // Unfilled slots are already zero since the register clears on every exit from HOLD.
                        if (idle == IDLE_MAX) begin
                            state       <= HOLD;
                            out_valid   <= 1'b1;
                            out_partial <= 1'b1;
                            out_count   <= cnt;
                            cnt         <= '0;
                            idle        <= '0;
                        end else begin
                            idle <= idle + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state       <= FILL;
                        out_valid   <= 1'b0;
                        out_data    <= '0;
                        out_partial <= 1'b0;
                        out_count   <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_afifo_word_assembler.sv
// tb/tb_afifo_word_assembler.sv - directed bench for afifo_word_assembler
module tb_afifo_word_assembler;

    logic        rclk = 1'b0;
    logic        r_nrst;
    logic [7:0]  fifo_rdata;
    logic        fifo_empty;
    logic        fifo_rinc;
    logic        flush;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_partial;
    logic [2:0]  out_count;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [0:63];
    logic [5:0] wr = '0;
    logic [5:0] rd = '0;

    assign fifo_empty = (wr == rd);
    assign fifo_rdata = mem[rd];

    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (fifo_rinc) rd <= rd + 6'd1;
    end

    afifo_word_assembler #(
        .DATA_WIDTH(8),
        .BEATS(4),
        .TIMEOUT(16)
    ) dut (
        .rclk(rclk),
        .r_nrst(r_nrst),
        .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty),
        .fifo_rinc(fifo_rinc),
        .flush(flush),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_partial(out_partial),
        .out_count(out_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr] = b;
        wr = wr + 6'd1;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(negedge rclk);
            n++;
        end
        check("valid_wait", {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        r_nrst    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge rclk);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data", {32'd0, out_data}, 64'd0);
        check("rst_count", {61'd0, out_count}, 64'd0);
        check("rst_partial", {63'd0, out_partial}, 64'd0);
        check("rst_rinc", {63'd0, fifo_rinc}, 64'd0);
        r_nrst = 1'b1;

        // Full word with consumer ready
        @(negedge rclk);
        out_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("w1_rinc%0d", i), {63'd0, fifo_rinc}, 64'd1);
            @(negedge rclk);
        end
        check("w1_valid", {63'd0, out_valid}, 64'd1);
        check("w1_data", {32'd0, out_data}, 64'h44332211);
        check("w1_count", {61'd0, out_count}, 64'd4);
        check("w1_partial", {63'd0, out_partial}, 64'd0);
        check("w1_rinc_hold", {63'd0, fifo_rinc}, 64'd0);
        @(negedge rclk);
        check("w1_valid_drop", {63'd0, out_valid}, 64'd0);
        check("w1_data_clr", {32'd0, out_data}, 64'd0);

        // Backpressure: first word held while FIFO still has data
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        #1;
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("w2_hold_data%0d", i), {32'd0, out_data}, 64'h04030201);
            check($sformatf("w2_hold_rinc%0d", i), {63'd0, fifo_rinc}, 64'd0);
            @(negedge rclk);
        end
        out_ready = 1'b1;
        @(negedge rclk);
        check("w2_accept", {63'd0, out_valid}, 64'd0);
        wait_valid(10);
        check("w3_data", {32'd0, out_data}, 64'h08070605);
        check("w3_count", {61'd0, out_count}, 64'd4);
        @(negedge rclk);
        check("w3_accept", {63'd0, out_valid}, 64'd0);

        // Timeout on a two-beat partial
        push(8'hAA); push(8'hBB);
        #1;
        for (int i = 1; i <= 17; i++) begin
            @(negedge rclk);
            check($sformatf("to_wait%0d", i), {63'd0, out_valid}, 64'd0);
        end
        @(negedge rclk);
        check("to_valid", {63'd0, out_valid}, 64'd1);
        check("to_data", {32'd0, out_data}, 64'h0000BBAA);
        check("to_count", {61'd0, out_count}, 64'd2);
        check("to_partial", {63'd0, out_partial}, 64'd1);
        @(negedge rclk);
        check("to_accept", {63'd0, out_valid}, 64'd0);

        // Pop on the would-be timeout cycle wins
        push(8'hAA);
        #1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge rclk);
            check($sformatf("nt_wait%0d", i), {63'd0, out_valid}, 64'd0);
        end
        push(8'hBB);
        #1;
        @(negedge rclk);
        check("nt_no_timeout", {63'd0, out_valid}, 64'd0);
        push(8'hCC); push(8'hDD);
        #1;
        wait_valid(10);
        check("nt_data", {32'd0, out_data}, 64'hDDCCBBAA);
        check("nt_partial", {63'd0, out_partial}, 64'd0);
        check("nt_count", {61'd0, out_count}, 64'd4);
        @(negedge rclk);

        // Flush after three beats
        push(8'h10); push(8'h20); push(8'h30); push(8'h40);
        push(8'h50); push(8'h60); push(8'h70);
        #1;
        repeat (3) @(negedge rclk);
        flush = 1'b1;
        #1;
        check("fl_rinc", {63'd0, fifo_rinc}, 64'd0);
        @(negedge rclk);
        flush = 1'b0;
        #1;
        check("fl_valid", {63'd0, out_valid}, 64'd0);
        check("fl_data_clr", {32'd0, out_data}, 64'd0);
        check("fl_rinc_after", {63'd0, fifo_rinc}, 64'd1);
        wait_valid(10);
        check("fl_data", {32'd0, out_data}, 64'h70605040);
        check("fl_count", {61'd0, out_count}, 64'd4);
        @(negedge rclk);

        // Asynchronous reset during HOLD
        out_ready = 1'b0;
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        #1;
        wait_valid(10);
        check("ar_data_pre", {32'd0, out_data}, 64'hD4C3B2A1);
        #2;
        r_nrst = 1'b0;
        #1;
        check("ar_valid", {63'd0, out_valid}, 64'd0);
        check("ar_data", {32'd0, out_data}, 64'd0);
        check("ar_count", {61'd0, out_count}, 64'd0);
        check("ar_partial", {63'd0, out_partial}, 64'd0);
        @(negedge rclk);
        r_nrst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
